// File: rtl/pkg_tpu.sv
// Shared TPU types: issue numbers and the reorder-buffer entry layout.
package pkg_tpu;

    localparam int ISSUE_NO_W = 8;

    typedef logic [ISSUE_NO_W-1:0] issue_no_t;

    // One ROB slot: valid, execution finished (commit), and its issue number.
    typedef struct packed {
        logic      v;
        logic      commit;
        issue_no_t issue_no;
    } rob_entry_t;

    localparam rob_entry_t ROB_ENTRY_RESET = '0;

    // A completion only matches a live entry carrying the same issue number.
    function automatic logic entry_match(input rob_entry_t ent, input issue_no_t no);
        return ent.v && (ent.issue_no == no);
    endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for a power-of-two circular buffer.
// We/Re must already be qualified by the caller (no store when full,
// no read when nothing is ready); Flush returns everything to empty.
module rob_ptr_ctrl #(
    parameter  int NUM_ENTRY = 16,
    localparam int PTR_W     = $clog2(NUM_ENTRY),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             We,
    input  logic             Re,
    input  logic             Flush,
    output logic [PTR_W-1:0] WAddr,
    output logic [PTR_W-1:0] RAddr,
    output logic [CNT_W-1:0] Num,
    output logic             Full,
    output logic             Empty
);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    // Next-state: pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (Flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (We) wptr_d = wptr_q + PTR_W'(1);
            if (Re) rptr_d = rptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(We) - CNT_W'(Re);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign WAddr = wptr_q;
    assign RAddr = rptr_q;
    assign Num   = cnt_q;
    assign Full  = (cnt_q == CNT_W'(NUM_ENTRY));
    assign Empty = (cnt_q == '0);

endmodule

// File: rtl/reorder_buff_mp.sv
// Multi-port reorder buffer. Instructions are allocated in order at the tail,
// completions arrive out of order from NUM_SRC sources (one cycle capture,
// then an associative search of all live entries), and the head retires in
// order once it is marked complete and the hazard unit grants it.
module reorder_buff_mp
    import pkg_tpu::*;
#(
    parameter  int NUM_ENTRY = 16,
    parameter  int NUM_SRC   = 4,
    localparam int PTR_W     = $clog2(NUM_ENTRY),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       I_Flush,
    input  logic                       I_Store,
    input  issue_no_t                  I_Issue_No,
    input  logic      [NUM_SRC-1:0]    I_Commit_Req,
    input  issue_no_t [NUM_SRC-1:0]    I_Commit_No,
    output logic      [NUM_SRC-1:0]    O_Commited,
    output logic      [NUM_SRC-1:0]    O_Commit_Miss,
    input  logic                       I_Commit_Grant,
    output logic                       O_Commit_Req,
    output issue_no_t                  O_Commit_No,
    output logic                       O_Full,
    output logic                       O_Empty,
    output logic      [CNT_W-1:0]      O_Num
);

    // ------------------------------------------------------------------
    // Pointer control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] num;
    logic             store_ok;
    logic             retire;

    rob_ptr_ctrl #(
        .NUM_ENTRY (NUM_ENTRY)
    ) u_ptr (
        .clock (clock),
        .reset (reset),
        .We    (store_ok),
        .Re    (retire),
        .Flush (I_Flush),
        .WAddr (wptr),
        .RAddr (rptr),
        .Num   (num),
        .Full  (full),
        .Empty (empty)
    );

    // ------------------------------------------------------------------
    // Completion capture stage
    // ------------------------------------------------------------------
    logic      [NUM_SRC-1:0] cap_req_q, cap_req_d;
    issue_no_t [NUM_SRC-1:0] cap_no_q,  cap_no_d;

    // A flush discards whatever completions arrive alongside it.
    always_comb begin
        cap_req_d = I_Commit_Req;
        cap_no_d  = I_Commit_No;
        if (I_Flush) begin
            cap_req_d = '0;
            cap_no_d  = '0;
        end
    end

    // Capture registers feeding next cycle's associative search.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_req_q <= '0;
            cap_no_q  <= '0;
        end else begin
            cap_req_q <= cap_req_d;
            cap_no_q  <= cap_no_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage and associative match
    // ------------------------------------------------------------------
    rob_entry_t entry_vec [NUM_ENTRY];
    logic [NUM_SRC-1:0][NUM_ENTRY-1:0] match;
    logic [NUM_SRC-1:0]                hit_src;
    logic [NUM_ENTRY-1:0]              hit_ent;
    rob_entry_t                        head;

    // Every captured request is compared against every entry in parallel.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        for (genvar gj = 0; gj < NUM_ENTRY; gj++) begin : g_cmp
            assign match[gi][gj] = cap_req_q[gi] & entry_match(entry_vec[gj], cap_no_q[gi]);
        end
        assign hit_src[gi] = |match[gi];
    end

    // Collapse the match matrix per entry: any source hitting it marks it done.
    always_comb begin
        hit_ent = '0;
        for (int e = 0; e < NUM_ENTRY; e++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                hit_ent[e] = hit_ent[e] | match[k][e];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_ENTRY; gi++) begin : g_ent
        rob_entry_t ent_q, ent_d;

        // Slot update priority: flush, retire-clear, allocate, commit-set.
        always_comb begin
            ent_d = ent_q;
            if (I_Flush) begin
                ent_d.v      = 1'b0;
                ent_d.commit = 1'b0;
            end else if (retire && (rptr == PTR_W'(gi))) begin
                ent_d.v      = 1'b0;
                ent_d.commit = 1'b0;
            end else if (store_ok && (wptr == PTR_W'(gi))) begin
                ent_d.v        = 1'b1;
                ent_d.commit   = 1'b0;
                ent_d.issue_no = I_Issue_No;
            end else if (hit_ent[gi]) begin
                ent_d.commit = 1'b1;
            end
        end

        // Slot register.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                ent_q <= ROB_ENTRY_RESET;
            end else begin
                ent_q <= ent_d;
            end
        end

        assign entry_vec[gi] = ent_q;
    end

    // ------------------------------------------------------------------
    // Allocation, retirement and outputs
    // ------------------------------------------------------------------
    assign head         = entry_vec[rptr];
    assign store_ok     = I_Store & ~full & ~I_Flush;
    assign O_Commit_Req = head.v & head.commit;
    assign O_Commit_No  = O_Commit_Req ? head.issue_no : '0;
    assign retire       = O_Commit_Req & I_Commit_Grant & ~I_Flush;

    // Acks are suppressed in a flush cycle since the entries are being discarded.
    assign O_Commited    = I_Flush ? '0 : hit_src;
    assign O_Commit_Miss = I_Flush ? '0 : (cap_req_q & ~hit_src);

    assign O_Full  = full;
    assign O_Empty = empty;
    assign O_Num   = num;

endmodule

// File: tb/tb_reorder_buff_mp.sv
// Directed bench for reorder_buff_mp: fill/drop, out-of-order completion,
// miss, multi-source hits, head retire race, pointer wrap, flush and reset.
module tb_reorder_buff_mp;
    import pkg_tpu::*;

    localparam int NE = 16;
    localparam int NS = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 store;
    issue_no_t            issue_no;
    logic      [NS-1:0]   creq;
    issue_no_t [NS-1:0]   cno;
    logic      [NS-1:0]   committed;
    logic      [NS-1:0]   miss;
    logic                 grant;
    logic                 oreq;
    issue_no_t            ono;
    logic                 full;
    logic                 empty;
    logic      [4:0]      num;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    reorder_buff_mp #(
        .NUM_ENTRY (NE),
        .NUM_SRC   (NS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .I_Flush        (flush),
        .I_Store        (store),
        .I_Issue_No     (issue_no),
        .I_Commit_Req   (creq),
        .I_Commit_No    (cno),
        .O_Commited     (committed),
        .O_Commit_Miss  (miss),
        .I_Commit_Grant (grant),
        .O_Commit_Req   (oreq),
        .O_Commit_No    (ono),
        .O_Full         (full),
        .O_Empty        (empty),
        .O_Num          (num)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-24s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_store(input issue_no_t n);
        store    = 1'b1;
        issue_no = n;
        cyc();
        store = 1'b0;
        #1;
    endtask

    // Completion on source 0; returns in the compare cycle (t+1).
    task automatic commit0(input issue_no_t n);
        creq   = 4'b0001;
        cno[0] = n;
        cyc();
        creq = '0;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   oreq,      1'b0);
        chk({tag, "_no"},    ono,       8'd0);
        chk({tag, "_ack"},   committed, 4'b0000);
        chk({tag, "_miss"},  miss,      4'b0000);
        chk({tag, "_full"},  full,      1'b0);
        chk({tag, "_empty"}, empty,     1'b1);
        chk({tag, "_num"},   num,       5'd0);
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        store    = 1'b0;
        grant    = 1'b0;
        issue_no = '0;
        creq     = '0;
        cno      = '0;

        // Reset state
        repeat (2) cyc();
        chk_reset_outputs("rst");
        reset = 1'b1;
        cyc();

        // Fill to 16, then a dropped 17th store
        for (int i = 0; i < NE; i++) do_store(issue_no_t'(i));
        chk("fill_full", full, 1'b1);
        chk("fill_num",  num,  5'd16);
        do_store(8'd99);
        chk("drop_num",  num,  5'd16);
        chk("drop_full", full, 1'b1);

        // Store while full with a same-cycle retire is still dropped
        commit0(8'd0);
        chk("full_ack0", committed, 4'b0001);
        cyc();
        chk("full_head_req", oreq, 1'b1);
        chk("full_head_no",  ono,  8'd0);
        store    = 1'b1;
        issue_no = 8'd99;
        grant    = 1'b1;
        cyc();
        store = 1'b0;
        grant = 1'b0;
        #1;
        chk("full_sr_num",  num,  5'd15);
        chk("full_sr_full", full, 1'b0);
        chk("full_sr_req",  oreq, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        chk("flush1_empty", empty, 1'b1);
        chk("flush1_num",   num,   5'd0);

        // Out-of-order completion, in-order retire
        do_store(8'd5);
        do_store(8'd6);
        do_store(8'd7);
        commit0(8'd7);
        chk("ooo_ack7", committed, 4'b0001);
        cyc();
        chk("ooo_req_after7", oreq, 1'b0);
        commit0(8'd6);
        chk("ooo_ack6", committed, 4'b0001);
        cyc();
        chk("ooo_req_after6", oreq, 1'b0);
        commit0(8'd5);
        chk("ooo_ack5", committed, 4'b0001);
        cyc();
        chk("ooo_req5", oreq, 1'b1);
        chk("ooo_no5",  ono,  8'd5);
        cyc();
        chk("ooo_hold_no",  ono, 8'd5);
        chk("ooo_hold_num", num, 5'd3);
        grant = 1'b1;
        cyc();
        chk("ooo_no6", ono, 8'd6);
        cyc();
        chk("ooo_no7", ono, 8'd7);
        cyc();
        grant = 1'b0;
        #1;
        chk("ooo_done_req",   oreq,  1'b0);
        chk("ooo_done_empty", empty, 1'b1);

        // Miss
        do_store(8'd1);
        do_store(8'd2);
        commit0(8'd9);
        chk("miss_pulse", miss,      4'b0001);
        chk("miss_ack",   committed, 4'b0000);
        cyc();
        chk("miss_gone", miss, 4'b0000);
        chk("miss_req",  oreq, 1'b0);
        chk("miss_num",  num,  5'd2);

        // Four sources in one cycle, two hitting the same entry
        do_store(8'd3);
        creq   = 4'b1111;
        cno[0] = 8'd1;
        cno[1] = 8'd2;
        cno[2] = 8'd3;
        cno[3] = 8'd1;
        cyc();
        creq = '0;
        #1;
        chk("conc_ack",  committed, 4'b1111);
        chk("conc_miss", miss,      4'b0000);
        cyc();
        chk("conc_req", oreq, 1'b1);
        chk("conc_no1", ono,  8'd1);
        grant = 1'b1;
        cyc();
        chk("conc_no2", ono, 8'd2);
        chk("conc_num", num, 5'd2);
        cyc();
        chk("conc_no3", ono, 8'd3);
        cyc();
        grant = 1'b0;
        #1;
        chk("conc_empty", empty, 1'b1);

        // Hit on the head in the same cycle it retires: still acked
        do_store(8'd40);
        creq   = 4'b0001;
        cno[0] = 8'd40;
        cyc();
        cyc();
        creq = '0;
        grant = 1'b1;
        #1;
        chk("race_ack", committed, 4'b0001);
        chk("race_req", oreq,      1'b1);
        cyc();
        grant = 1'b0;
        #1;
        chk("race_empty", empty,     1'b1);
        chk("race_req0",  oreq,      1'b0);
        chk("race_ack0",  committed, 4'b0000);

        // Wrap: 20 simultaneous store/retire pairs
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        do_store(8'd0);
        commit0(8'd0);
        cyc();
        for (int i = 0; i < 20; i++) begin
            chk("wrap_no", ono, 32'(i));
            store    = 1'b1;
            issue_no = issue_no_t'(i + 1);
            grant    = 1'b1;
            cyc();
            store = 1'b0;
            grant = 1'b0;
            #1;
            chk("wrap_num", num, 5'd1);
            commit0(issue_no_t'(i + 1));
            cyc();
        end

        // Flush alongside three pending completions
        do_store(8'd10);
        do_store(8'd11);
        do_store(8'd12);
        creq   = 4'b0111;
        cno[0] = 8'd10;
        cno[1] = 8'd11;
        cno[2] = 8'd12;
        flush  = 1'b1;
        cyc();
        creq  = '0;
        flush = 1'b0;
        #1;
        chk("fl_ack",   committed, 4'b0000);
        chk("fl_miss",  miss,      4'b0000);
        chk("fl_empty", empty,     1'b1);
        chk("fl_req",   oreq,      1'b0);
        cyc();
        chk("fl_ack2",  committed, 4'b0000);
        chk("fl_miss2", miss,      4'b0000);

        // Reset in the middle of a capture
        do_store(8'd4);
        creq   = 4'b0001;
        cno[0] = 8'd4;
        cyc();
        creq  = '0;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_rst_ack",   committed, 4'b0000);
        chk("post_rst_req",   oreq,      1'b0);
        chk("post_rst_empty", empty,     1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buff_mp.md
REORDER_BUFF_MP -- requirements
Module: reorder_buff_mp

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 16, ROB depth (power of two, >=2).
REQ-002 SHALL have parameter NUM_SRC, default 4, number of commit sources.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous reset, asserted at 0.
REQ-006 SHALL have port I_Flush  in  1  synchronous flush of all entries.
REQ-007 SHALL have port I_Store  in  1  allocate entry at tail.
REQ-008 SHALL have port I_Issue_No  in  issue_no_t  issue number to allocate.
REQ-009 SHALL have port I_Commit_Req  in  NUM_SRC  per-source completion request.
REQ-010 SHALL have port I_Commit_No  in  issue_no_t[NUM_SRC]  per-source completed issue number.
REQ-011 SHALL have port O_Commited  out  NUM_SRC  per-source hit acknowledge.
REQ-012 SHALL have port O_Commit_Miss  out  NUM_SRC  per-source no-match pulse.
REQ-013 SHALL have port I_Commit_Grant  in  1  hazard unit accepts head retire.
REQ-014 SHALL have port O_Commit_Req  out  1  head entry ready to retire.
REQ-015 SHALL have port O_Commit_No  out  issue_no_t  head issue number.
REQ-016 SHALL have ports O_Full, O_Empty  out  1 each, and O_Num  out  $clog2(NUM_ENTRY)+1  occupancy.

Function
REQ-017 SHALL store on I_Store & ~O_Full & ~I_Flush: tail entry gets v=1, commit=0, issue_no=I_Issue_No; tail advances modulo NUM_ENTRY; entry visible next cycle.
REQ-018 SHALL drop I_Store when O_Full, even if a retire occurs the same cycle; no state change.
REQ-019 SHALL register each source's request/number in cycle t (capture stage); in t+1 compare against all valid entries.
REQ-020 SHALL, in t+1 on match, set commit on every matching valid entry (visible t+2) and pulse O_Commited[k] one cycle.
REQ-021 SHALL, in t+1 on no match, pulse O_Commit_Miss[k] one cycle and change no entry; an entry stored in cycle t+1 does not match.
REQ-022 SHALL allow several sources to hit the same or different entries in one cycle; all hits acked.
REQ-023 SHALL drive O_Commit_Req = head.v & head.commit combinationally; O_Commit_No = head.issue_no when O_Commit_Req, else 0.
REQ-024 SHALL retire on O_Commit_Req & I_Commit_Grant: head v/commit cleared, head advances modulo NUM_ENTRY; at most one retire per cycle.
REQ-025 SHALL hold head while O_Commit_Req=1 and I_Commit_Grant=0; younger committed entries wait (in-order).
REQ-026 SHALL give retire-clear priority over a same-cycle commit set on the head entry; the hit is still acked.
REQ-027 SHALL update count = count + store_accepted - retire each cycle; O_Full = (count==NUM_ENTRY), O_Empty = (count==0), O_Num = count.
REQ-028 SHALL support simultaneous store and retire with count unchanged and both pointers advancing, including pointer wrap.
REQ-029 SHALL on I_Flush (highest priority) clear all v/commit, zero head/tail/count, and discard capture-stage requests; next cycle O_Commited, O_Commit_Miss, O_Commit_Req = 0.
REQ-030 SHALL ignore I_Commit_Grant when O_Commit_Req=0.

Reset
REQ-031 SHALL on reset=0 asynchronously clear all entries, pointers, count and capture registers.
REQ-032 SHALL hold outputs at O_Commit_Req=0, O_Commit_No=0, O_Commited=0, O_Commit_Miss=0, O_Full=0, O_Empty=1, O_Num=0 during reset.
REQ-033 SHALL abandon an in-flight capture or retire on reset mid-operation; no ack is produced after reset release.

Structure
REQ-034 SHALL take issue_no_t from pkg_tpu and add there typedef rob_entry_t {v, commit, issue_no}.
REQ-035 SHALL place head/tail/count logic in sub-module rob_ptr_ctrl (inputs We, Re, Flush; outputs WAddr, RAddr, Num, Full, Empty).

Verification
REQ-036 SHALL test fill: 16 stores (issue 0..15) -> O_Full=1, O_Num=16; 17th store dropped, O_Num stays 16.
REQ-037 SHALL test out-of-order: store 5,6,7; commit 7 then 6 -> O_Commit_Req stays 0; commit 5 -> retires 5,6,7 in order across three granted cycles.
REQ-038 SHALL test miss: commit number 9 with ROB holding 1,2 -> O_Commit_Miss pulse at t+1, O_Commited=0, no entry changed.
REQ-039 SHALL test concurrency: 4 sources commit 1,2,3,1 in one cycle -> all four O_Commited at t+1; head 1 retires on grant.
REQ-040 SHALL test wrap: 20 store/retire pairs at NUM_ENTRY=16 -> pointers wrap, O_Num constant, O_Commit_No order 0..19.
REQ-041 SHALL test flush and reset: flush with 3 pending requests -> no acks, O_Empty=1 next cycle; reset=0 mid-capture -> outputs at reset values.
